// File: rtl/seq_mult_pkg.sv
// Shared state encoding and operand helpers for the seq_mult_param multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_IDLE  = 2'd1,
        ST_MULT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned MAX_WIDTH = 64;

    // Caller passes the operand zero-extended plus its own sign bit; only the low WIDTH bits are meaningful.
    function automatic logic [MAX_WIDTH-1:0] abs_val(input logic [MAX_WIDTH-1:0] value,
                                                     input logic                 sign_bit,
                                                     input logic                 signed_mode);
        if (signed_mode && sign_bit)
            abs_val = ~value + 64'd1;
        else
            abs_val = value;
    endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Shift-add datapath: operand magnitudes, accumulator/multiplier pair, counter, sign fix-up.
// Optional SEQ_MULT_EARLY_EXIT_EN stops once the remaining multiplier bits are all zero.
module seq_mult_datapath
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic                 i_finish,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    input  logic                 i_signed,
    output logic                 o_last,
    output logic [2*WIDTH-1:0]   o_result
);

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH:0]     r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;
    logic [2*WIDTH-1:0] r_result;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_mp_nxt;
    logic [2*WIDTH-1:0] w_prod;

    assign w_sum     = r_acc + (r_mplier[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_nxt = w_sum[WIDTH:1];
    assign w_mp_nxt  = {w_sum[0], r_mplier[WIDTH-1:1]};

`ifdef SEQ_MULT_EARLY_EXIT_EN
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] w_rem_nxt;

    assign w_rem_nxt = r_rem >> 1;
    assign o_last    = (w_rem_nxt == '0) || (r_cnt == CNT_W'(WIDTH-1));
    // Leaving early leaves the partial product offset; shift out the unprocessed positions.
    assign w_prod    = {w_acc_nxt, w_mp_nxt} >> (CNT_W'(WIDTH-1) - r_cnt);

    always_ff @(posedge Clock) begin
        if (Reset)
            r_rem <= '0;
        else if (i_load)
            r_rem <= WIDTH'(abs_val(MAX_WIDTH'(i_b), i_b[WIDTH-1], i_signed));
        else if (i_step)
            r_rem <= w_rem_nxt;
    end
`else
    assign o_last = (r_cnt == CNT_W'(WIDTH-1));
    assign w_prod = {w_acc_nxt, w_mp_nxt};
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else if (i_load) begin
            r_mcand  <= WIDTH'(abs_val(MAX_WIDTH'(i_a), i_a[WIDTH-1], i_signed));
            r_mplier <= WIDTH'(abs_val(MAX_WIDTH'(i_b), i_b[WIDTH-1], i_signed));
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
        end else if (i_step) begin
            r_acc    <= {1'b0, w_acc_nxt};
            r_mplier <= w_mp_nxt;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (i_finish)
                r_result <= r_neg ? -w_prod : w_prod;
        end
    end

    assign o_result = r_result;

endmodule

// File: rtl/seq_mult_param.sv
// Parametrised iterative multiplier with IDLE/DONE handshake; FSM over seq_mult_datapath.
// Optional macro SEQ_MULT_EARLY_EXIT_EN enables early exit from MULT.
module seq_mult_param
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [WIDTH-1:0]     iData_A,
    input  logic [WIDTH-1:0]     iData_B,
    input  logic                 iSigned,
    input  logic                 iValid_Data,
    input  logic                 iAcknoledged,
    output logic                 oIdle,
    output logic                 oDone,
    output logic [2*WIDTH-1:0]   oResult
);

    state_t r_state;
    logic   r_idle;
    logic   r_done;
    logic   w_load;
    logic   w_step;
    logic   w_last;
    logic   w_finish;

    assign w_load   = (r_state == ST_IDLE) & iValid_Data;
    assign w_step   = (r_state == ST_MULT);
    assign w_finish = w_step & w_last;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_RESET;
            r_idle  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_RESET: begin
                    r_state <= ST_IDLE;
                    r_idle  <= 1'b1;
                end
                ST_IDLE: begin
                    if (iValid_Data) begin
                        r_state <= ST_MULT;
                        r_idle  <= 1'b0;
                    end
                end
                ST_MULT: begin
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (iAcknoledged) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                        r_idle  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RESET;
                    r_idle  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    seq_mult_datapath #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_datapath (
        .Clock    (Clock),
        .Reset    (Reset),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_finish (w_finish),
        .i_a      (iData_A),
        .i_b      (iData_B),
        .i_signed (iSigned),
        .o_last   (w_last),
        .o_result (oResult)
    );

    assign oIdle = r_idle;
    assign oDone = r_done;

endmodule

// File: tb/tb_seq_mult_param.sv
// Self-checking bench for seq_mult_param: cycle model at WIDTH=8 plus a WIDTH=32 product sweep.
module tb_seq_mult_param;

    localparam int unsigned W = 8;
`ifdef SEQ_MULT_EARLY_EXIT_EN
    localparam int unsigned LAT_B0 = 1;
    localparam int unsigned LAT_B3 = 2;
`else
    localparam int unsigned LAT_B0 = 8;
    localparam int unsigned LAT_B3 = 8;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  a = '0, b = '0;
    logic        sg = 1'b0, vld = 1'b0, ack = 1'b0;
    logic        idle, done;
    logic [15:0] res;

    logic [31:0] a32 = '0, b32 = '0;
    logic        sg32 = 1'b0, v32 = 1'b0, ack32 = 1'b0;
    logic        idle32, done32;
    logic [63:0] res32;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    seq_mult_param #(.WIDTH(8)) u_dut (
        .Clock(clk), .Reset(rst), .iData_A(a), .iData_B(b), .iSigned(sg),
        .iValid_Data(vld), .iAcknoledged(ack), .oIdle(idle), .oDone(done), .oResult(res)
    );

    seq_mult_param #(.WIDTH(32)) u_dut32 (
        .Clock(clk), .Reset(rst), .iData_A(a32), .iData_B(b32), .iSigned(sg32),
        .iValid_Data(v32), .iAcknoledged(ack32), .oIdle(idle32), .oDone(done32), .oResult(res32)
    );

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
        logic signed [15:0] sx, sy, p;
        sx = {{8{x[7]}}, x};
        sy = {{8{y[7]}}, y};
        p  = sx * sy;
        ref8 = s ? p : ({8'd0, x} * {8'd0, y});
    endfunction

    // Number of cycles spent multiplying for a given multiplier operand.
    function automatic int unsigned mult_cycles(input logic [7:0] y, input logic s);
`ifdef SEQ_MULT_EARLY_EXIT_EN
        logic [7:0] m;
        m = (s && y[7]) ? (~y + 8'd1) : y;
        mult_cycles = 1;
        for (int i = 0; i < 8; i++)
            if (m[i]) mult_cycles = 32'(i + 1);
`else
        mult_cycles = (y[0] === 1'bx) ? 0 : W;
`endif
    endfunction

    int          m_phase = 0;      // 0 reset, 1 idle, 2 busy, 3 done
    int unsigned m_left = 0;
    logic [15:0] m_prod = '0, m_res = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_res   = '0;
        end else begin
            case (m_phase)
                0: m_phase = 1;
                1: if (vld) begin
                       m_prod  = ref8(a, b, sg);
                       m_left  = mult_cycles(b, sg);
                       m_phase = 2;
                   end
                2: begin
                       m_left = m_left - 1;
                       if (m_left == 0) begin
                           m_phase = 3;
                           m_res   = m_prod;
                       end
                   end
                default: if (ack) m_phase = 1;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (idle !== (m_phase == 1) || done !== (m_phase == 3) || res !== m_res) begin
                miscompares++;
                $display("FAIL model t=%0t: idle=%b done=%b result=%h, expected idle=%b done=%b result=%h",
                         $time, idle, done, res, (m_phase == 1), (m_phase == 3), m_res);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic s,
                        input logic [15:0] exp_res, input int unsigned exp_lat,
                        input int unsigned hold, input string name);
        int unsigned k;
        bit seen;
        @(negedge clk);
        a = av; b = bv; sg = s; vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        a = ~av; b = ~bv; sg = ~s;
        k = 0; seen = 1'b0;
        while (!seen && k < 100) begin
            if (done === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        chk({name, " latency"}, 64'(k), 64'(exp_lat));
        chk({name, " result"}, 64'(res), 64'(exp_res));
        repeat (hold) @(negedge clk);
        chk({name, " held"}, 64'(res), 64'(exp_res));
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk({name, " idle after ack"}, 64'(idle), 64'd1);
    endtask

    logic [31:0] edges [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    initial begin
        int unsigned k;
        bit seen;
        bit any_done;
        logic [31:0] x, y;
        logic s;
        logic signed [63:0] sx, sy;
        logic [63:0] e;
        logic [7:0] ra, rb;

        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset idle", 64'(idle), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset result", 64'(res), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle after reset", 64'(idle), 64'd1);

        run8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 8, 20, "u_ff_ff");
        run8(8'h80, 8'h80, 1'b1, 16'h4000, 8, 2, "s_min_min");
        run8(8'hFD, 8'h07, 1'b1, 16'hFFEB, mult_cycles(8'h07, 1'b1), 2, "s_m3_7");
        run8(8'hFD, 8'h07, 1'b0, 16'h06EB, mult_cycles(8'h07, 1'b0), 2, "u_fd_7");
        run8(8'h07, 8'hFD, 1'b1, 16'hFFEB, mult_cycles(8'hFD, 1'b1), 1, "s_7_m3");
        run8(8'h7F, 8'h80, 1'b1, 16'hC080, 8, 1, "s_max_min");
        run8(8'h5A, 8'h00, 1'b0, 16'h0000, LAT_B0, 1, "b_zero");
        run8(8'h80, 8'h00, 1'b1, 16'h0000, LAT_B0, 1, "s_neg_zero");
        run8(8'h05, 8'h03, 1'b0, 16'h000F, LAT_B3, 1, "a5_b3");

        // Abort mid-multiply with reset.
        @(negedge clk);
        a = 8'h33; b = 8'h44; sg = 1'b0; vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort result", 64'(res), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort idle", 64'(idle), 64'd0);
        @(negedge clk);
        chk("abort back to idle", 64'(idle), 64'd1);
        any_done = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) any_done = 1'b1;
        end
        chk("abort no done", 64'(any_done), 64'd0);

        // Protocol gating.
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ack in idle ignored", 64'(idle), 64'd1);
        a = 8'h12; b = 8'h34; sg = 1'b0; vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        @(negedge clk);
        a = 8'h55; b = 8'h66; vld = 1'b1; ack = 1'b1;
        @(negedge clk);
        vld = 1'b0; ack = 1'b0;
        k = 0; seen = 1'b0;
        while (!seen && k < 30) begin
            if (done === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        chk("gate done seen", 64'(seen), 64'd1);
        chk("gate result", 64'(res), 64'h03A8);
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        chk("valid in done ignored", 64'(done), 64'd1);
        vld = 1'b1; ack = 1'b1;
        @(negedge clk);
        vld = 1'b0; ack = 1'b0;
        chk("valid+ack idle", 64'(idle), 64'd1);
        chk("valid+ack done", 64'(done), 64'd0);
        repeat (5) @(negedge clk);
        chk("no recapture", 64'(idle), 64'd1);
        chk("result kept after ack", 64'(res), 64'h03A8);

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            s  = 1'($urandom_range(0, 1));
            run8(ra, rb, s, ref8(ra, rb, s), mult_cycles(rb, s), 0, "rand8");
        end

        for (int i = 0; i < 300; i++) begin
            if (i < 50) begin
                x = edges[i % 5];
                y = edges[(i / 5) % 5];
                s = 1'(i / 25);
            end else begin
                x = $urandom;
                y = $urandom;
                s = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            a32 = x; b32 = y; sg32 = s; v32 = 1'b1;
            @(negedge clk);
            v32 = 1'b0;
            k = 0; seen = 1'b0;
            while (!seen && k < 100) begin
                if (done32 === 1'b1) seen = 1'b1;
                else begin
                    @(negedge clk);
                    k++;
                end
            end
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
            e  = s ? 64'(sx * sy) : ({32'd0, x} * {32'd0, y});
            chk("w32 product", seen ? res32 : 64'hDEAD_0000_0000_DEAD, e);
            ack32 = 1'b1;
            @(negedge clk);
            ack32 = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
